// File: rtl/store_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : store_load_sequencer
// Purpose  : Sequences the loading of one serial frame into a downstream
//            n-bit storage register. On a frame request it clears the storage
//            register, then writes each strobed serial bit at the next bit
//            index, and finally reports frame completion.
// Ports    : clock      - system clock, all logic on posedge
//            reset      - synchronous, active-high
//            start      - frame request pulse, honoured only when idle
//            abort      - cancel the frame in progress
//            bit_valid  - serial bit strobe
//            bit_data   - serial bit, qualified by bit_valid
//            oeenable   - active-low load strobe to the storage register
//            ramadrs    - {bit index, frame sequence number}
//            txda       - data bit to the storage register
//            clr_n      - active-low clear to the storage register
//            busy       - frame in progress (CLEAR, ARM, FINISH)
//            done       - one-cycle frame-complete pulse
//            error      - one-cycle pulse on abort (or timeout) of a frame
// Option   : STORE_SEQ_TIMEOUT_EN - adds parameter timeout_cycles and an
//            idle-gap watchdog in ARM that ends the frame like an abort.
// Revision : 1.0 - initial release
// ============================================================================
module store_load_sequencer #(
    parameter int counter_size   = 4,
    parameter int buffer_size    = 16
`ifdef STORE_SEQ_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 64
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      bit_valid,
    input  logic                      bit_data,
    output logic                      oeenable,
    output logic [2*counter_size:0]   ramadrs,
    output logic                      txda,
    output logic                      clr_n,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [counter_size-1:0] c_IDX_LAST = counter_size'(buffer_size - 1);
    localparam logic [counter_size-1:0] c_IDX_ONE  = counter_size'(1);
    localparam logic [counter_size:0]   c_SEQ_ONE  = (counter_size + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_ARM    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [counter_size-1:0] r_index;
    logic [counter_size-1:0] r_adr_idx;
    logic [counter_size:0]   r_seq;
    logic                    r_oe_n;
    logic                    r_txda;
    logic                    r_clr_n;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    logic                    w_strobe;
    logic                    w_abort;
    logic                    w_timeout;
    logic                    w_complete;

`ifdef STORE_SEQ_TIMEOUT_EN
    localparam int c_GW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(timeout_cycles - 1);
    localparam logic [c_GW-1:0] c_GAP_ONE  = c_GW'(1);

    logic [c_GW-1:0] r_gap;

    // Gap counter only runs in ARM; it is zero on ARM entry because it is
    // held clear in every other state, and each strobe restarts it.
    always_ff @(posedge clock) begin
        if (reset || r_state != S_ARM || bit_valid) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + c_GAP_ONE;
        end
    end
`endif

    // Next-state and per-cycle event decode
    always_comb begin
        w_next    = r_state;
        w_strobe  = 1'b0;
        w_abort   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = S_ARM;
            end
            S_ARM: begin
                if (bit_valid) begin
                    w_strobe = 1'b1;
                    if (r_index == c_IDX_LAST) begin
                        w_next = S_FINISH;
                    end
                end
`ifdef STORE_SEQ_TIMEOUT_EN
                else if (r_gap == c_GAP_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort outranks the bit strobe and the frame completion
        if (r_state != S_IDLE && abort) begin
            w_abort  = 1'b1;
            w_strobe = 1'b0;
            w_next   = S_IDLE;
        end
    end

    assign w_complete = (r_state == S_FINISH) && !w_abort;

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_adr_idx <= '0;
            r_seq     <= '0;
            r_oe_n    <= 1'b1;
            r_txda    <= 1'b0;
            r_clr_n   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_clr_n <= (w_next != S_CLEAR);
            r_oe_n  <= !w_strobe;
            r_done  <= w_complete;
            // Timeout cannot fire when abort wins, so this is one pulse
            r_error <= w_abort | w_timeout;

            if (r_state == S_CLEAR) begin
                r_index <= '0;
            end else if (w_strobe) begin
                r_index <= (r_index == c_IDX_LAST) ? '0 : r_index + c_IDX_ONE;
            end

            // Address and data are presented in the cycle after the strobe
            if (w_strobe) begin
                r_txda    <= bit_data;
                r_adr_idx <= r_index;
            end

            if (w_complete) begin
                r_seq <= r_seq + c_SEQ_ONE;
            end
        end
    end

    assign oeenable = r_oe_n;
    assign ramadrs  = {r_adr_idx, r_seq};
    assign txda     = r_txda;
    assign clr_n    = r_clr_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_store_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_load_sequencer
// Purpose  : Directed self-checking bench for store_load_sequencer. A small
//            behavioural storage register captures txda at ramadrs index on
//            every edge where oeenable is low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_load_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_data;
    logic       oeenable;
    logic [8:0] ramadrs;
    logic       txda;
    logic       clr_n;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clock = ~clock;

    store_load_sequencer #(
        .counter_size   (4),
        .buffer_size    (16)
`ifdef STORE_SEQ_TIMEOUT_EN
        ,
        .timeout_cycles (8)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .oeenable  (oeenable),
        .ramadrs   (ramadrs),
        .txda      (txda),
        .clr_n     (clr_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Storage register model and event counters
    logic [15:0] store;
    logic [3:0]  mon_idx;
    logic [4:0]  first_seq;
    int          oe_cnt    = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          order_err = 0;
    int          seq_err   = 0;

    always @(posedge clock) begin
        if (reset) begin
            mon_idx <= 4'd0;
        end else begin
            if (!clr_n) mon_idx <= 4'd0;
            if (!oeenable) begin
                store[ramadrs[8:5]] <= txda;
                oe_cnt  <= oe_cnt + 1;
                mon_idx <= mon_idx + 4'd1;
                if (ramadrs[8:5] != mon_idx) order_err <= order_err + 1;
                if (mon_idx == 4'd0) first_seq <= ramadrs[4:0];
                else if (ramadrs[4:0] != first_seq) seq_err <= seq_err + 1;
            end
            if (done)  done_cnt <= done_cnt + 1;
            if (error) err_cnt  <= err_cnt + 1;
        end
    end

    int total = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full frame, LSB first; maxgap>1 inserts 0..maxgap-1 idle cycles
    // between strobes, noisy drives start during those idle cycles.
    task automatic send_frame(input logic [15:0] data, input int maxgap, input bit noisy);
        int oe0;
        int d0;
        int g;
        oe0 = oe_cnt;
        d0  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_clr_n", {31'd0, clr_n}, 32'd0);
        check("clear_busy", {31'd0, busy}, 32'd1);
        tick();
        check("arm_clr_n", {31'd0, clr_n}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_data  = data[i];
            tick();
            bit_valid = 1'b0;
            if (i < 15) begin
                g = (maxgap > 1) ? int'($urandom_range(0, maxgap - 1)) : 0;
                repeat (g) begin
                    start = noisy;
                    tick();
                    start = 1'b0;
                end
            end
        end
        tick();
        check("done_pulse", {31'd0, done}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("done_clear", {31'd0, done}, 32'd0);
        check("store", {16'd0, store}, {16'd0, data});
        check("oe_low_count", oe_cnt - oe0, 32'd16);
        check("done_count", done_cnt - d0, 32'd1);
        check("index_order", order_err, 32'd0);
        check("seq_stable", seq_err, 32'd0);
    endtask

    initial begin
        int e0;
        int d0;
        int o0;
        int hit;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;

        // Reset behaviour
        tick();
        check("rst_clr_n", {31'd0, clr_n}, 32'd0);
        check("rst_oe", {31'd0, oeenable}, 32'd1);
        check("rst_ramadrs", {23'd0, ramadrs}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_txda", {31'd0, txda}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_clr_n", {31'd0, clr_n}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_oe", {31'd0, oeenable}, 32'd1);

        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_error", {31'd0, error}, 32'd0);
        tick();
        check("idle_abort_count", err_cnt, 32'd0);

        // First and second frames, back-to-back strobes
        send_frame(16'hA5C3, 1, 1'b0);
        check("seq_frame0", {27'd0, first_seq}, 32'd0);
        send_frame(16'hA5C3, 1, 1'b0);
        check("seq_frame1", {27'd0, first_seq}, 32'd1);

        // Frames 3..32, then the sequence number wraps to 0
        for (int f = 2; f < 32; f++) begin
            send_frame(16'($urandom), 1, 1'b0);
        end
        check("seq_wrap", {27'd0, ramadrs[4:0]}, 32'd0);

        // Spaced strobes with stray starts during ARM
        send_frame(16'h3C5A, 5, 1'b1);
        check("seq_after_wrap", {27'd0, first_seq}, 32'd0);

        // Abort together with the 8th strobe
        e0 = err_cnt;
        d0 = done_cnt;
        o0 = oe_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            bit_data  = i[0];
            tick();
        end
        bit_valid = 1'b1;
        abort     = 1'b1;
        tick();
        bit_valid = 1'b0;
        abort     = 1'b0;
        check("abort_oe", {31'd0, oeenable}, 32'd1);
        check("abort_error", {31'd0, error}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        check("abort_error_clear", {31'd0, error}, 32'd0);
        tick();
        check("abort_oe_count", oe_cnt - o0, 32'd7);
        check("abort_err_count", err_cnt - e0, 32'd1);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_seq_kept", {27'd0, ramadrs[4:0]}, 32'd1);
        send_frame(16'h1234, 2, 1'b0);
        check("seq_after_abort", {27'd0, first_seq}, 32'd1);

        // Three strobes then silence
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_data  = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        e0 = err_cnt;
`ifdef STORE_SEQ_TIMEOUT_EN
        hit = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (error && hit == 0) hit = k;
        end
        check("timeout_latency", hit, 32'd8);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_err_count", err_cnt - e0, 32'd1);
`else
        hit = 0;
        repeat (20) tick();
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        check("no_timeout_error", err_cnt - e0, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("cleanup_error", {31'd0, error}, 32'd1);
        check("cleanup_busy", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire
